// File: rtl/mux_ctrl_pkg.sv
// Shared definitions for the two-requester mux arbiter.
//   state_t : arbiter FSM encoding (IDLE, GRANT_A, GRANT_B)
//   SEL_A / SEL_B : mux select values. They also encode "which requester"
//                   wherever a one-bit side identifier is needed, such as the
//                   last-served pointer.
package mux_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_A = 2'd1,
        ST_GRANT_B = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2_to_1.sv
// One-bit 2-to-1 multiplexer, the basic cell of the shared mux path.
// Ports:
//   a   : input selected when sel = 0
//   b   : input selected when sel = 1
//   sel : select
//   y   : selected output
module mux2_to_1 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick.
// Ports:
//   req_a, req_b : pending requests
//   ptr          : requester served last (SEL_A / SEL_B)
//   any_req      : at least one requester is asking
//   pick_b       : 1 when B wins, 0 when A wins (meaningful only with any_req)
module rr_pick2
    import mux_ctrl_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic ptr,
    output logic any_req,
    output logic pick_b
);

    assign any_req = req_a | req_b;

    // B wins when it is the only requester, or when both are requesting
    // and A was the one served last.
    assign pick_b = req_b & (~req_a | (ptr == SEL_A));

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared W-bit 2-to-1 mux path.
// It grants one of two valid/last/data streams at a time, drives the mux
// select, and forwards the granted stream to one valid/ready sink.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   req_a/data_a/last_a  : stream A (valid, payload, end-of-packet)
//   req_b/data_b/last_b  : stream B
//   out_ready            : sink accepts a beat
//   gnt_a, gnt_b         : beat consumed from A / B this cycle
//   out_valid/out_data/out_last : forwarded stream
//   sel                  : registered mux select (0 = A, 1 = B)
//   busy                 : a grant is held
module mux2_rr_arbiter
    import mux_ctrl_pkg::*;
#(
    parameter int W         = 8,
    parameter int MAX_BEATS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_a,
    input  logic [W-1:0] data_a,
    input  logic         last_a,
    input  logic         req_b,
    input  logic [W-1:0] data_b,
    input  logic         last_b,
    input  logic         out_ready,
    output logic         gnt_a,
    output logic         gnt_b,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         sel,
    output logic         busy
);

    localparam int               CNT_W   = $clog2(MAX_BEATS) + 1;
    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(MAX_BEATS - 1);

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic             ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic pick_any;
    logic pick_b;
    logic grant_b;
    logic granted_req;
    logic granted_last;
    logic other_req;
    logic xfer;
    logic rel_now;

    rr_pick2 u_pick (
        .req_a   (req_a),
        .req_b   (req_b),
        .ptr     (ptr_q),
        .any_req (pick_any),
        .pick_b  (pick_b)
    );

    // Shared datapath: one 1-bit mux per data bit plus one for the last flag,
    // all steered by the registered select.
    for (genvar i = 0; i < W; i++) begin : g_data_mux
        mux2_to_1 u_mux (
            .a   (data_a[i]),
            .b   (data_b[i]),
            .sel (sel_q),
            .y   (out_data[i])
        );
    end

    mux2_to_1 u_last_mux (
        .a   (last_a),
        .b   (last_b),
        .sel (sel_q),
        .y   (out_last)
    );

    // Signals of the side currently holding the grant, derived from the
    // state so the handshake does not depend on the select register.
    assign grant_b      = (state_q == ST_GRANT_B);
    assign granted_req  = grant_b ? req_b  : req_a;
    assign granted_last = grant_b ? last_b : last_a;
    assign other_req    = grant_b ? req_a  : req_b;

    // Next-state, counter and handshake logic. The reset term in out_valid
    // keeps a beat from completing in a cycle where reset is asserted, so a
    // packet interrupted by reset is dropped without a half-finished beat.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        out_valid = 1'b0;
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        xfer      = 1'b0;
        rel_now   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = pick_b ? ST_GRANT_B : ST_GRANT_A;
                    sel_d   = pick_b ? SEL_B : SEL_A;
                    cnt_d   = '0;
                end
            end

            ST_GRANT_A, ST_GRANT_B: begin
                out_valid = granted_req & rst_n;
                xfer      = out_valid & out_ready;
                gnt_a     = xfer & ~grant_b;
                gnt_b     = xfer &  grant_b;
                rel_now   = xfer & (granted_last | (cnt_q == CNT_CAP));

                if (rel_now) begin
                    // Hand straight over to a waiting requester, else go idle.
                    ptr_d = grant_b ? SEL_B : SEL_A;
                    cnt_d = '0;
                    if (other_req) begin
                        state_d = grant_b ? ST_GRANT_A : ST_GRANT_B;
                        sel_d   = grant_b ? SEL_A : SEL_B;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers. The pointer resets to B so that A wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_A;
            ptr_q   <= SEL_B;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel  = sel_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter. A behavioural model tracks who
// owns the path, how many beats the owner has sent and who was served last.
// Directed scenarios come first, followed by a randomized run.
module tb_mux2_rr_arbiter;

    localparam int W         = 8;
    localparam int MAX_BEATS = 4;

    logic         clk;
    logic         rstN;
    logic         reqA, lastA, reqB, lastB, outReady;
    logic [W-1:0] dataA, dataB;
    logic         gntA, gntB, outValid, outLast, sel, busy;
    logic [W-1:0] outData;

    int total = 0;
    int bad   = 0;

    // Model state: owner -1 = nobody, 0 = A, 1 = B
    int   owner;
    int   lastServed;
    int   beats;
    logic mSel;
    logic expValid, expGntA, expGntB;

    logic [W-1:0] seenQ[$];
    logic [W-1:0] expSeq[$];
    int           aIdx;
    bit           bDone;

    mux2_rr_arbiter #(.W(W), .MAX_BEATS(MAX_BEATS)) dut (
        .clk       (clk),
        .rst_n     (rstN),
        .req_a     (reqA),
        .data_a    (dataA),
        .last_a    (lastA),
        .req_b     (reqB),
        .data_b    (dataB),
        .last_b    (lastB),
        .out_ready (outReady),
        .gnt_a     (gntA),
        .gnt_b     (gntB),
        .out_valid (outValid),
        .out_data  (outData),
        .out_last  (outLast),
        .sel       (sel),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs just after a rising edge, then settle.
    task automatic applyStimulus(input logic rn, input logic ra, input logic [W-1:0] da,
                                 input logic la, input logic rb, input logic [W-1:0] db,
                                 input logic lb, input logic rdy);
        rstN     = rn;
        reqA     = ra;
        dataA    = da;
        lastA    = la;
        reqB     = rb;
        dataB    = db;
        lastB    = lb;
        outReady = rdy;
        #3;
    endtask

    // Compare every output against the model for the current inputs.
    task automatic checkOutput();
        expValid = rstN && ((owner == 0 && reqA) || (owner == 1 && reqB));
        expGntA  = expValid && (owner == 0) && outReady;
        expGntB  = expValid && (owner == 1) && outReady;
        checkVal("busy",      busy,     (owner >= 0));
        checkVal("sel",       sel,      mSel);
        checkVal("out_valid", outValid, expValid);
        checkVal("gnt_a",     gntA,     expGntA);
        checkVal("gnt_b",     gntB,     expGntB);
        checkVal("out_data",  outData,  mSel ? dataB : dataA);
        checkVal("out_last",  outLast,  mSel ? lastB : lastA);
    endtask

    task automatic resetModel();
        owner      = -1;
        mSel       = 1'b0;
        lastServed = 1;
        beats      = 0;
    endtask

    // Advance the model by the cycle just checked, then clock the DUT.
    task automatic tick();
        if (!rstN) begin
            resetModel();
        end else if (owner < 0) begin
            if (reqA && reqB)  owner = 1 - lastServed;
            else if (reqA)     owner = 0;
            else if (reqB)     owner = 1;
            if (owner >= 0) begin
                mSel  = (owner == 1);
                beats = 0;
            end
        end else if (expValid && outReady) begin
            beats++;
            if ((owner == 0 ? lastA : lastB) || beats == MAX_BEATS) begin
                lastServed = owner;
                beats      = 0;
                if (owner == 0 ? reqB : reqA) begin
                    owner = 1 - owner;
                    mSel  = (owner == 1);
                end else begin
                    owner = -1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstN = 1'b0; reqA = 1'b0; reqB = 1'b0; lastA = 1'b0; lastB = 1'b0;
        dataA = '0; dataB = '0; outReady = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetModel();

        $display("[TB] reset held with both requesting");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1);
            checkOutput();
            checkVal("reset_busy", busy, 1'b0);
            checkVal("reset_sel",  sel,  1'b0);
            tick();
        end

        $display("[TB] tie with single-beat packets");
        applyStimulus(1'b1, 1'b1, 8'h10, 1'b1, 1'b1, 8'h20, 1'b1, 1'b1);
        checkOutput();
        tick();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 8'(8'h10 + i), 1'b1, 1'b1, 8'(8'h20 + i), 1'b1, 1'b1);
            checkOutput();
            checkVal("tie_gnt_a", gntA, ((i % 2) == 0));
            checkVal("tie_gnt_b", gntB, ((i % 2) == 1));
            checkVal("tie_sel",   sel,  ((i % 2) == 1));
            tick();
        end

        $display("[TB] beat cap against a waiting requester");
        aIdx  = 0;
        bDone = 1'b0;
        for (int c = 0; c < 30; c++) begin
            applyStimulus(1'b1, (aIdx < 10), 8'(8'h11 + aIdx), 1'b0, !bDone, 8'hB7, 1'b1, 1'b1);
            checkOutput();
            if (outValid && outReady) seenQ.push_back(outData);
            if (expGntA) aIdx++;
            if (expGntB) bDone = 1'b1;
            tick();
        end
        for (int k = 0; k < 4; k++) expSeq.push_back(8'(8'h11 + k));
        expSeq.push_back(8'hB7);
        for (int k = 4; k < 10; k++) expSeq.push_back(8'(8'h11 + k));
        checkVal("cap_beat_count", seenQ.size(), expSeq.size());
        for (int k = 0; k < expSeq.size() && k < seenQ.size(); k++) begin
            checkVal($sformatf("cap_order_%0d", k), seenQ[k], expSeq[k]);
        end

        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput();
        tick();

        $display("[TB] backpressure on B");
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
        checkOutput();
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
            checkOutput();
            checkVal("bp_valid", outValid, 1'b1);
            checkVal("bp_data",  outData,  8'hA5);
            checkVal("bp_gnt_b", gntB,     1'b0);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1);
        checkOutput();
        checkVal("bp_release_gnt_b", gntB, 1'b1);
        tick();

        $display("[TB] bubble then reset mid-packet");
        // A single-beat A packet leaves A as the last one served.
        applyStimulus(1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput();
        tick();
        applyStimulus(1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput();
        checkVal("pre_gnt_a", gntA, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b1, 8'h60, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput();
        tick();
        applyStimulus(1'b1, 1'b1, 8'h61, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput();
        tick();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 8'h62, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
            checkOutput();
            checkVal("bubble_busy",  busy,     1'b1);
            checkVal("bubble_valid", outValid, 1'b0);
            checkVal("bubble_sel",   sel,      1'b0);
            tick();
        end
        applyStimulus(1'b1, 1'b1, 8'h62, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput();
        checkVal("bubble_resume_gnt_a", gntA, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1, 8'h63, 1'b0, 1'b1, 8'h70, 1'b0, 1'b1);
        checkOutput();
        checkVal("rst_cycle_gnt_a", gntA, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 8'h63, 1'b0, 1'b1, 8'h70, 1'b0, 1'b1);
        checkOutput();
        checkVal("post_rst_busy", busy, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 8'h63, 1'b0, 1'b1, 8'h70, 1'b0, 1'b1);
        checkOutput();
        checkVal("post_rst_tie_sel",   sel,  1'b0);
        checkVal("post_rst_tie_gnt_a", gntA, 1'b1);
        tick();

        $display("[TB] randomized traffic");
        for (int c = 0; c < 600; c++) begin
            applyStimulus(($urandom_range(0, 49) != 0),
                          1'($urandom_range(0, 3) != 0), 8'($urandom),
                          1'($urandom_range(0, 2) == 0),
                          1'($urandom_range(0, 3) != 0), 8'($urandom),
                          1'($urandom_range(0, 2) == 0),
                          1'($urandom_range(0, 9) < 7));
            checkOutput();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
